bram_stream_reader: RTL

- Read-side client for the simple dual-port BRAM: drives the BRAM read port (address out, registered data in, 1-cycle read latency).
- Converts a (base, length) job into a valid/ready stream with full backpressure support and 1 word/cycle sustained throughput.
- Sits between a BRAM filled by a writer (e.g. host/DMA loading reads/haplotypes) and the PairHMM compute pipeline that consumes words.

---
 rtl/bram_stream_reader_pkg.sv | 5 +
 rtl/bram_reader_skid_fifo.sv | 51 +++++
 rtl/bram_stream_reader.sv | 92 +++++++++
 3 files changed

// File: rtl/bram_stream_reader_pkg.sv
// bram_stream_reader_pkg: shared state encoding and buffer sizing for the BRAM stream reader
package bram_stream_reader_pkg;
  typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;
  localparam int BUF_DEPTH = 2;
endpackage

// File: rtl/bram_reader_skid_fifo.sv
// bram_reader_skid_fifo: 2-entry data+last buffer absorbing BRAM read latency under backpressure
// Ports: clock_i/reset_n_i clock and async active-low reset; flush_i empties the buffer;
// push_i/push_data_i/push_last_i write side; pop_i read side; data_o/last_o head entry;
// valid_o non-empty; count_o occupancy 0..2.
module bram_reader_skid_fifo
  import bram_stream_reader_pkg::*;
#(
  parameter int W = 64
) (
  input  logic         clock_i,
  input  logic         reset_n_i,
  input  logic         flush_i,
  input  logic         push_i,
  input  logic [W-1:0] push_data_i,
  input  logic         push_last_i,
  input  logic         pop_i,
  output logic [W-1:0] data_o,
  output logic         last_o,
  output logic         valid_o,
  output logic [1:0]   count_o
);
  logic [W-1:0] mem_d [BUF_DEPTH];
  logic         mem_l [BUF_DEPTH];
  logic         wr_ptr, rd_ptr;

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      mem_d   <= '{default: '0};
      mem_l   <= '{default: 1'b0};
      wr_ptr  <= 1'b0;
      rd_ptr  <= 1'b0;
      count_o <= 2'd0;
    end else if (flush_i) begin
      wr_ptr  <= 1'b0;
      rd_ptr  <= 1'b0;
      count_o <= 2'd0;
    end else begin
      if (push_i) begin
        mem_d[wr_ptr] <= push_data_i;
        mem_l[wr_ptr] <= push_last_i;
        wr_ptr        <= ~wr_ptr;
      end
      if (pop_i) rd_ptr <= ~rd_ptr;
      count_o <= count_o + {1'b0, push_i} - {1'b0, pop_i};
    end
  end

  assign data_o  = mem_d[rd_ptr];
  assign last_o  = mem_l[rd_ptr];
  assign valid_o = count_o != 2'd0;
endmodule

// File: rtl/bram_stream_reader.sv
// bram_stream_reader: turns a (base, length) job into a valid/ready stream read from a 1-cycle-latency BRAM
// Ports: clock_i/reset_n_i clock and async active-low reset; start_i/base_addr_i/length_i job request;
// abort_i flushes the job; busy_o/done_o job status; bram_addr_o/bram_data_i BRAM read port;
// data_o/valid_o/ready_i/last_o output stream.
module bram_stream_reader
  import bram_stream_reader_pkg::*;
#(
  parameter int RAM_WIDTH = 64,
  parameter int RAM_DEPTH = 512,
  localparam int ADDR_W = $clog2(RAM_DEPTH)
) (
  input  logic                 clock_i,
  input  logic                 reset_n_i,
  input  logic                 start_i,
  input  logic                 abort_i,
  input  logic [ADDR_W-1:0]    base_addr_i,
  input  logic [ADDR_W:0]      length_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [ADDR_W-1:0]    bram_addr_o,
  input  logic [RAM_WIDTH-1:0] bram_data_i,
  output logic [RAM_WIDTH-1:0] data_o,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic                 last_o
);
  localparam logic [ADDR_W:0]   ONE      = 1;
  localparam logic [ADDR_W-1:0] ADDR_MAX = ADDR_W'(RAM_DEPTH - 1);

  state_t          state;
  logic [ADDR_W:0] remaining;
  logic            inflight, inflight_last;
  logic [1:0]      count;
  logic            pop, issue;
  logic [ADDR_W-1:0] next_addr;

  assign pop       = valid_o & ready_i;
  // buffered + in flight - leaving must leave room for one more word
  assign issue     = (state == READ) && ({1'b0, count} + {2'b0, inflight} < 3'd2 + {2'b0, pop});
  assign next_addr = (bram_addr_o == ADDR_MAX) ? '0 : bram_addr_o + 1'b1;
  assign busy_o    = state != IDLE;

  bram_reader_skid_fifo #(.W(RAM_WIDTH)) u_fifo (
    .clock_i     (clock_i),
    .reset_n_i   (reset_n_i),
    .flush_i     (abort_i),
    .push_i      (inflight & ~abort_i),
    .push_data_i (bram_data_i),
    .push_last_i (inflight_last),
    .pop_i       (pop),
    .data_o      (data_o),
    .last_o      (last_o),
    .valid_o     (valid_o),
    .count_o     (count)
  );

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state         <= IDLE;
      remaining     <= '0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
      done_o        <= 1'b0;
      bram_addr_o   <= '0;
    end else begin
      done_o        <= 1'b0;
      inflight      <= issue & ~abort_i;
      inflight_last <= issue && remaining == ONE;
      if (abort_i) state <= IDLE;
      else begin
        case (state)
          IDLE: if (start_i) begin
            bram_addr_o <= base_addr_i;
            remaining   <= length_i;
            if (length_i == '0) done_o <= 1'b1;
            else state <= READ;
          end
          READ: if (issue) begin
            bram_addr_o <= next_addr;
            remaining   <= remaining - ONE;
            if (remaining == ONE) state <= DRAIN;
          end
          DRAIN: if (pop && last_o) begin
            state  <= IDLE;
            done_o <= 1'b1;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule
